// File: rtl/mp_line_writer_if.sv
// Pixel stream in, line-FIFO write port out.
// Shared by mp_line_writer and its testbench.
interface mp_line_writer_if #(
    parameter int PIX_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [PIX_W-1:0]   in_data;
    logic [7:0]         fifo_full;
    logic [7:0]         fifo_wr;
    logic [2*PIX_W-1:0] wr_data;
    logic               frame_done;

    modport master (
        output in_valid,
        output in_data,
        output fifo_full,
        input  in_ready,
        input  fifo_wr,
        input  wr_data,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  fifo_full,
        output in_ready,
        output fifo_wr,
        output wr_data,
        output frame_done
    );
endinterface

// File: rtl/mp_line_writer.sv
// Pairs raster pixels into words and steers them to one of
// eight line FIFOs by bank, row parity and pair parity.
module mp_line_writer #(
    parameter int PIX_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] ifm_width,
    mp_line_writer_if.slave bus
);

    typedef enum logic {
        S_FIRST,
        S_SECOND
    } state_t;

    state_t           state;
    logic [PIX_W-1:0] held;
    logic [4:0]       pair_cnt;
    logic [5:0]       row_cnt;
    logic             small_map;

    logic [2:0] target;
    logic       frame_start;
    logic       last_pair;
    logic       last_row;
    logic       in_ready_c;
    logic       accept;

    // index = bank*4 + row_par*2 + pair_par, bank = row[1]
    assign target      = {row_cnt[1], row_cnt[0], pair_cnt[0]};
    assign frame_start = (state == S_FIRST) &&
                         (pair_cnt == 5'd0) &&
                         (row_cnt == 6'd0);
    assign last_pair   = pair_cnt == (small_map ? 5'd12 : 5'd25);
    assign last_row    = row_cnt == (small_map ? 6'd25 : 6'd51);

    always_comb begin
        in_ready_c = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FIRST:  in_ready_c = 1'b1;
                S_SECOND: in_ready_c = !bus.fifo_full[target];
                default:  in_ready_c = 1'b0;
            endcase
        end
    end

    assign bus.in_ready = in_ready_c;
    assign accept       = bus.in_valid & in_ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_FIRST;
            held           <= '0;
            pair_cnt       <= '0;
            row_cnt        <= '0;
            small_map      <= 1'b0;
            bus.fifo_wr    <= '0;
            bus.wr_data    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.fifo_wr    <= '0;
            bus.frame_done <= 1'b0;
            if (accept) begin
                unique case (state)
                    S_FIRST: begin
                        held  <= bus.in_data;
                        state <= S_SECOND;
                        // map size is frozen for the whole frame
                        if (frame_start)
                            small_map <= (ifm_width == 9'd26);
                    end
                    S_SECOND: begin
                        bus.fifo_wr <= 8'd1 << target;
                        bus.wr_data <= {bus.in_data, held};
                        state       <= S_FIRST;
                        if (last_pair) begin
                            pair_cnt <= '0;
                            if (last_row) begin
                                row_cnt        <= '0;
                                bus.frame_done <= 1'b1;
                            end else begin
                                row_cnt <= row_cnt + 6'd1;
                            end
                        end else begin
                            pair_cnt <= pair_cnt + 5'd1;
                        end
                    end
                    default: state <= S_FIRST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mp_line_writer.sv
// Directed and random stimulus against a pixel-index model
// of the line writer's steering and framing rules.
module tb_mp_line_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] ifm_width;

    always #5 clk = ~clk;

    mp_line_writer_if #(.PIX_W(16)) bus ();

    mp_line_writer #(.PIX_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .ifm_width (ifm_width),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    // model: k = accepted pixels into the current frame
    int          k = 0;
    int          p_m = 13;
    logic [15:0] held_m = '0;
    logic [7:0]  exp_wr = '0;
    logic [31:0] exp_data = '0;
    logic        exp_done = 1'b0;
    logic        armed = 1'b0;
    int          wr_seen = 0;
    int          done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [15:0] d,
                         input logic [7:0] full, input logic r,
                         input logic [8:0] w);
        int row, pair, t;
        logic rdy;
        @(negedge clk);
        if (armed) begin
            chk("fifo_wr", 32'(bus.fifo_wr), 32'(exp_wr));
            chk("wr_data", bus.wr_data, exp_data);
            chk("frame_done", 32'(bus.frame_done), 32'(exp_done));
            if (bus.fifo_wr != 8'd0) wr_seen++;
            if (bus.frame_done) done_seen++;
        end
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.fifo_full = full;
        ifm_width     = w;
        #1;
        row  = k / (2 * p_m);
        pair = (k % (2 * p_m)) / 2;
        t    = ((row / 2) % 2) * 4 + (row % 2) * 2 + (pair % 2);
        rdy  = !r && ((k % 2 == 0) || !full[t]);
        if (armed || r)
            chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        exp_wr   = '0;
        exp_done = 1'b0;
        if (r) begin
            k        = 0;
            exp_data = '0;
            armed    = 1'b1;
        end else if (v && rdy) begin
            if (k % 2 == 0) begin
                if (k == 0) p_m = (w == 9'd26) ? 13 : 26;
                held_m = d;
                k++;
            end else begin
                exp_wr   = 8'(1 << t);
                exp_data = {d, held_m};
                k++;
                if (k == 4 * p_m * p_m) begin
                    exp_done = 1'b1;
                    k        = 0;
                end
            end
        end
    endtask

    function automatic logic [8:0] rand_w();
        return ($urandom % 2 == 0) ? 9'd26 : 9'd52;
    endfunction

    initial begin
        int n;
        logic [15:0] a, b;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.fifo_full = '0;
        ifm_width     = 9'd26;

        cycle(1'b0, 16'h0, 8'h0, 1'b1, 9'd26);
        cycle(1'b0, 16'h0, 8'h0, 1'b1, 9'd26);

        // first pair of a 26x26 frame
        cycle(1'b1, 16'h0001, 8'h0, 1'b0, 9'd26);
        cycle(1'b1, 16'h0002, 8'h0, 1'b0, 9'd26);
        @(posedge clk);
        #1;
        chk("first_wr", 32'(bus.fifo_wr), 32'h01);
        chk("first_data", bus.wr_data, 32'h00020001);

        // pair 1 held off by upnext0 full
        cycle(1'b1, 16'h0003, 8'h0, 1'b0, 9'd26);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 16'h0004, 8'h02, 1'b0, 9'd26);
        cycle(1'b1, 16'h0004, 8'h0, 1'b0, 9'd26);
        @(posedge clk);
        #1;
        chk("release_wr", 32'(bus.fifo_wr), 32'h02);
        chk("release_data", bus.wr_data, 32'h00040003);

        // rest of frame: random gaps, full flags, width toggles
        n = 0;
        while (k != 0 && n < 20000) begin
            cycle(($urandom % 4) != 0, 16'($urandom),
                  (($urandom % 3) == 0) ? 8'($urandom) : 8'h0,
                  1'b0, rand_w());
            n++;
        end
        chk("frame26_bound", 32'(k), 32'd0);
        cycle(1'b0, 16'h0, 8'h0, 1'b0, 9'd26);

        // reset discards a half-formed pair
        cycle(1'b1, 16'hdead, 8'h0, 1'b0, 9'd26);
        cycle(1'b0, 16'h0, 8'h0, 1'b1, 9'd26);
        a = 16'($urandom);
        b = 16'($urandom);
        cycle(1'b1, a, 8'h0, 1'b0, 9'd26);
        cycle(1'b1, b, 8'h0, 1'b0, 9'd26);
        @(posedge clk);
        #1;
        chk("post_rst_wr", 32'(bus.fifo_wr), 32'h01);
        chk("post_rst_data", bus.wr_data, {b, a});

        // full 52x52 frame
        cycle(1'b0, 16'h0, 8'h0, 1'b1, 9'd52);
        wr_seen   = 0;
        done_seen = 0;
        n = 0;
        while (n < 40000) begin
            cycle(($urandom % 5) != 0, 16'($urandom),
                  (($urandom % 6) == 0) ? 8'($urandom) : 8'h0,
                  1'b0, (k == 0) ? 9'd52 : rand_w());
            n++;
            if (k == 0 && exp_done) break;
        end
        cycle(1'b0, 16'h0, 8'h0, 1'b0, 9'd52);
        chk("w52_writes", 32'(wr_seen), 32'd1352);
        chk("w52_done", 32'(done_seen), 32'd1);

        // two 26x26 frames back to back at full rate
        wr_seen   = 0;
        done_seen = 0;
        for (int i = 0; i < 2 * 676; i++)
            cycle(1'b1, 16'($urandom), 8'h0, 1'b0, 9'd26);
        cycle(1'b0, 16'h0, 8'h0, 1'b0, 9'd26);
        chk("b2b_writes", 32'(wr_seen), 32'd676);
        chk("b2b_done", 32'(done_seen), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mp_line_writer.md
MP_LINE_WRITER -- requirements
Module: mp_line_writer

Interface
REQ-001 The block SHALL have one parameter: PIX_W, default 16, pixel width in bits.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ifm_width  in  9  feature-map width; 26 selects 26x26 map, any other value selects 52x52.
REQ-005 in_valid  in  1  input pixel valid.
REQ-006 in_ready  out  1  input pixel accepted when in_valid & in_ready.
REQ-007 in_data  in  PIX_W  pixel, raster order, left-to-right, top-to-bottom.
REQ-008 fifo_full  in  8  full flags; index 0 up0, 1 upnext0, 2 down0, 3 downnext0, 4 up1, 5 upnext1, 6 down1, 7 downnext1.
REQ-009 fifo_wr  out  8  one-hot write strobes, same index map as fifo_full.
REQ-010 wr_data  out  2*PIX_W  shared write word for whichever fifo_wr bit is set.
REQ-011 frame_done  out  1  one-cycle pulse coinciding with the last word write of a frame.

Function
REQ-012 Pixels SHALL be paired horizontally: first pixel of pair -> wr_data[15:0], second -> wr_data[31:16].
REQ-013 Pairs per row P SHALL be 13 if ifm_width==26, else 26; rows per frame R = 2*P.
REQ-014 ifm_width SHALL be sampled only at frame start (all counters zero, state S_FIRST); mid-frame changes have no effect until next frame.
REQ-015 Target index SHALL be bank*4 + row_par*2 + pair_par: row_par = row index LSB (0 up, 1 down); pair_par = pair index LSB within row (0 primary, 1 next); bank = (row index / 2) LSB.
REQ-016 FSM states: S_FIRST (hold register empty), S_SECOND (first pixel held).
REQ-017 S_FIRST: in_ready=1; accept -> latch pixel, go S_SECOND.
REQ-018 S_SECOND: in_ready = !fifo_full[target]; accept -> form word, go S_FIRST, advance pair counter.
REQ-019 fifo_wr[target] and wr_data SHALL be registered, asserted exactly 1 cycle after the second-pixel handshake; fifo_wr is 0 otherwise.
REQ-020 Full flag is checked only at second-pixel accept; block is the sole writer, so no write is dropped.
REQ-021 Pair counter wraps P-1 -> 0 and increments row counter; row counter wraps R-1 -> 0, ending the frame.
REQ-022 frame_done SHALL assert with the fifo_wr strobe of pair P-1 of row R-1; next frame starts at bank 0, row 0.
REQ-023 in_valid low in either state: hold state, no counter change, no write.
REQ-024 Back-to-back frames SHALL run without idle cycles when no FIFO is full.
REQ-025 Throughput: one pixel per cycle, one word per two cycles, when unblocked.

Reset
REQ-026 rst high SHALL on next edge force: state S_FIRST, all counters 0, bank 0, held pixel discarded, fifo_wr=0, wr_data=0, frame_done=0.
REQ-027 During rst high in_ready SHALL be 0; reset mid-pair or mid-frame discards the partial pair with no write.
REQ-028 First frame after reset SHALL use ifm_width as sampled on the first post-reset accept.

Verification
REQ-029 ifm_width=26, pixels 0x0001,0x0002 at row 0 -> one cycle later fifo_wr=0x01, wr_data=0x00020001.
REQ-030 Width 26, stream 26 pixels of row 1 -> 13 writes alternating fifo_wr 0x04/0x08, first word holding pixels 26,27.
REQ-031 Width 26, rows 2-3 -> writes on indices 4-7 only; row 4 returns to indices 0-1.
REQ-032 fifo_full[1]=1 while second pixel of pair 1 row 0 pending -> in_ready=0, no write; release full -> write 0x02 one cycle after accept.
REQ-033 Width 52, full frame 2704 pixels -> 1352 writes, single frame_done with last write; ifm_width toggled mid-frame ignored.
REQ-034 rst pulse after first pixel of pair -> no write; next two pixels yield fifo_wr=0x01 with those pixels.
